// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared size codes, FSM states and request-decode helpers for the load/store unit
package dmem_lsu_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam int BE_W = 5;
  typedef enum logic {IDLE, ACCESS} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_HALF ? off[0] : size == SIZE_WORD ? |off : size != SIZE_BYTE;
  endfunction
  function automatic logic [3:0] lanes(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_BYTE ? 4'b0001 << off : size == SIZE_HALF ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
    return size == SIZE_BYTE ? {4{wdata[7:0]}} : size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed lane of the read word and sign/zero-extends it
module dmem_load_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] di,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = 8'(di >> {off, 3'b000});
  assign h = off[1] ? di[31:16] : di[15:0];
  assign data = size == SIZE_BYTE ? {{24{b[7] & ~uns}}, b} :
                size == SIZE_HALF ? {{16{h[15] & ~uns}}, h} : di;
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store initiator driving the CSN/WEN/BE/READY data-memory handshake
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            REQ_VALID,
  input  logic            REQ_WRITE,
  input  logic [1:0]      REQ_SIZE,
  input  logic            REQ_UNSIGNED,
  input  logic [31:0]     REQ_ADDR,
  input  logic [31:0]     REQ_WDATA,
  output logic            STALL,
  output logic            LOAD_VALID,
  output logic [31:0]     LOAD_DATA,
  output logic            MISALIGNED,
  output logic            TIMEOUT_ERR,
  output logic            D_MEM_CSN,
  output logic            D_MEM_WEN,
  output logic [BE_W-1:0] D_MEM_BE,
  output logic [31:0]     D_MEM_ADDR,
  output logic [31:0]     D_MEM_DOUT,
  input  logic [31:0]     D_MEM_DI,
  input  logic            D_READY
);
  state_t      state;
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic [15:0] cnt;
  logic        mis;
  logic        tmo;
  logic [31:0] aligned;
  assign mis = misaligned(REQ_SIZE, REQ_ADDR[1:0]);
  // A zero TIMEOUT turns the watchdog off entirely
  assign tmo = state == ACCESS && !D_READY && TIMEOUT != 0 && cnt == 16'(TIMEOUT - 1);
  assign STALL = state == IDLE ? REQ_VALID && !mis : !D_READY && !tmo;
  assign MISALIGNED = state == IDLE && REQ_VALID && mis;
  assign TIMEOUT_ERR = tmo;
  assign LOAD_VALID = state == ACCESS && D_READY && !wr_q;
  assign LOAD_DATA = LOAD_VALID ? aligned : '0;
  dmem_load_align u_align (
    .di   (D_MEM_DI),
    .off  (off_q),
    .size (size_q),
    .uns  (uns_q),
    .data (aligned)
  );
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= IDLE;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SIZE_BYTE;
      off_q      <= 2'b00;
      cnt        <= '0;
      D_MEM_CSN  <= 1'b1;
      D_MEM_WEN  <= 1'b1;
      D_MEM_BE   <= '0;
      D_MEM_ADDR <= '0;
      D_MEM_DOUT <= '0;
    end else if (state == IDLE) begin
      if (REQ_VALID && !mis) begin
        state      <= ACCESS;
        wr_q       <= REQ_WRITE;
        uns_q      <= REQ_UNSIGNED;
        size_q     <= REQ_SIZE;
        off_q      <= REQ_ADDR[1:0];
        cnt        <= '0;
        D_MEM_CSN  <= 1'b0;
        D_MEM_WEN  <= !REQ_WRITE;
        D_MEM_BE   <= {!REQ_WRITE && !REQ_UNSIGNED && REQ_SIZE != SIZE_WORD, lanes(REQ_SIZE, REQ_ADDR[1:0])};
        D_MEM_ADDR <= {REQ_ADDR[31:2], 2'b00};
        D_MEM_DOUT <= replicate(REQ_SIZE, REQ_WDATA);
      end
    end else if (D_READY || tmo) begin
      state     <= IDLE;
      D_MEM_CSN <= 1'b1;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and randomized checks of dmem_lsu against a transaction-level model
module tb_dmem_lsu;
  localparam int TO = 4;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        REQ_VALID = 1'b0;
  logic        REQ_WRITE = 1'b0;
  logic [1:0]  REQ_SIZE = 2'b00;
  logic        REQ_UNSIGNED = 1'b0;
  logic [31:0] REQ_ADDR = '0;
  logic [31:0] REQ_WDATA = '0;
  logic [31:0] D_MEM_DI = '0;
  logic        D_READY = 1'b0;
  logic        STALL, LOAD_VALID, MISALIGNED, TIMEOUT_ERR, D_MEM_CSN, D_MEM_WEN;
  logic [31:0] LOAD_DATA, D_MEM_ADDR, D_MEM_DOUT;
  logic [4:0]  D_MEM_BE;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dmem_lsu #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_SIZE(REQ_SIZE),
    .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .STALL(STALL),
    .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA), .MISALIGNED(MISALIGNED), .TIMEOUT_ERR(TIMEOUT_ERR),
    .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_BE(D_MEM_BE), .D_MEM_ADDR(D_MEM_ADDR),
    .D_MEM_DOUT(D_MEM_DOUT), .D_MEM_DI(D_MEM_DI), .D_READY(D_READY)
  );

  // Model: one outstanding request and the number of READY-low cycles it has waited
  logic        m_busy = 1'b0;
  logic        m_wr = 1'b0;
  logic        m_uns = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic [1:0]  m_off = 2'b00;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  int          m_wait = 0;

  function automatic int nb(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic logic [31:0] mask(input int n);
    return n >= 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
  endfunction

  function automatic logic bad(input logic [1:0] s, input logic [1:0] off);
    return s == 2'b11 || (int'(off) % nb(s)) != 0;
  endfunction

  function automatic logic [4:0] exp_be(input logic wr, input logic uns, input logic [1:0] s, input logic [1:0] off);
    logic [3:0] l;
    l = 4'(((1 << nb(s)) - 1) << off);
    return {!wr && !uns && nb(s) < 4, l};
  endfunction

  function automatic logic [31:0] exp_dout(input logic [1:0] s, input logic [31:0] wd);
    logic [31:0] lo;
    lo = wd & mask(nb(s));
    return nb(s) == 1 ? lo * 32'h0101_0101 : nb(s) == 2 ? lo * 32'h0001_0001 : lo;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] s, input logic [1:0] off, input logic uns, input logic [31:0] di);
    logic [31:0] v;
    int n;
    n = nb(s);
    v = (di >> (8 * off)) & mask(n);
    if (!uns && n < 4 && v[8 * n - 1]) v = v | ~mask(n);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) m_busy <= 1'b0;
    else if (!m_busy) begin
      if (REQ_VALID && !bad(REQ_SIZE, REQ_ADDR[1:0])) begin
        m_busy  <= 1'b1;
        m_wr    <= REQ_WRITE;
        m_uns   <= REQ_UNSIGNED;
        m_size  <= REQ_SIZE;
        m_off   <= REQ_ADDR[1:0];
        m_addr  <= REQ_ADDR;
        m_wdata <= REQ_WDATA;
        m_wait  <= 0;
      end
    end else if (D_READY || m_wait == TO - 1) m_busy <= 1'b0;
    else m_wait <= m_wait + 1;
  end

  task automatic compare();
    logic terr, lv, mis;
    if (!RSTn) begin
      chk("rst_csn", D_MEM_CSN, 1);
      chk("rst_stall", STALL, 0);
      chk("rst_lv", LOAD_VALID, 0);
      chk("rst_mis", MISALIGNED, 0);
      chk("rst_terr", TIMEOUT_ERR, 0);
    end else if (!m_busy) begin
      mis = REQ_VALID && bad(REQ_SIZE, REQ_ADDR[1:0]);
      chk("idle_csn", D_MEM_CSN, 1);
      chk("idle_stall", STALL, REQ_VALID && !mis);
      chk("idle_mis", MISALIGNED, mis);
      chk("idle_lv", LOAD_VALID, 0);
      chk("idle_terr", TIMEOUT_ERR, 0);
    end else begin
      terr = !D_READY && m_wait == TO - 1;
      lv = D_READY && !m_wr;
      chk("acc_csn", D_MEM_CSN, 0);
      chk("acc_wen", D_MEM_WEN, !m_wr);
      chk("acc_be", D_MEM_BE, exp_be(m_wr, m_uns, m_size, m_off));
      chk("acc_addr", D_MEM_ADDR, m_addr & 32'hFFFF_FFFC);
      if (m_wr) chk("acc_dout", D_MEM_DOUT, exp_dout(m_size, m_wdata));
      chk("acc_stall", STALL, !D_READY && !terr);
      chk("acc_terr", TIMEOUT_ERR, terr);
      chk("acc_mis", MISALIGNED, 0);
      chk("acc_lv", LOAD_VALID, lv);
      if (lv) chk("acc_data", LOAD_DATA, exp_load(m_size, m_off, m_uns, D_MEM_DI));
    end
  endtask

  always @(negedge CLK) begin
    #2;
    compare();
  end

  task automatic cyc(input logic v, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input logic rdy, input logic [31:0] di);
    @(negedge CLK);
    REQ_VALID = v;
    REQ_WRITE = w;
    REQ_SIZE = s;
    REQ_UNSIGNED = u;
    REQ_ADDR = a;
    REQ_WDATA = wd;
    D_READY = rdy;
    D_MEM_DI = di;
    #3;
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0, rdy, 32'h0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    RSTn = 1'b0;
    idle(0);
    idle(1);
    chk("reset_csn", D_MEM_CSN, 1);
    chk("reset_wen", D_MEM_WEN, 1);
    chk("reset_be", D_MEM_BE, 0);
    chk("reset_addr", D_MEM_ADDR, 0);
    chk("reset_dout", D_MEM_DOUT, 0);
    chk("reset_stall", STALL, 0);
    chk("reset_lv", LOAD_VALID, 0);
    chk("reset_data", LOAD_DATA, 0);
    chk("reset_mis", MISALIGNED, 0);
    chk("reset_terr", TIMEOUT_ERR, 0);
    RSTn = 1'b1;
    cyc(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 32'h0);
    chk("lw_accept_stall", STALL, 1);
    chk("lw_accept_csn", D_MEM_CSN, 1);
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 32'hDEADBEEF);
    chk("lw_csn", D_MEM_CSN, 0);
    chk("lw_be", D_MEM_BE, 5'b01111);
    chk("lw_addr", D_MEM_ADDR, 32'h100);
    chk("lw_lv", LOAD_VALID, 1);
    chk("lw_data", LOAD_DATA, 32'hDEADBEEF);
    chk("lw_stall", STALL, 0);
    idle(1);
    chk("lw_done_csn", D_MEM_CSN, 1);
    chk("lw_done_lv", LOAD_VALID, 0);
    cyc(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h0);
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 32'h80123456);
    chk("lb_be", D_MEM_BE, 5'b11000);
    chk("lb_data", LOAD_DATA, 32'hFFFFFF80);
    cyc(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h0);
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 32'h80123456);
    chk("lbu_be", D_MEM_BE, 5'b01000);
    chk("lbu_data", LOAD_DATA, 32'h00000080);
    n = 0;
    cyc(1, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 0, 32'h0);
    n += int'(STALL);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2'b10, 0, 32'h999, 32'h0, 0, 32'h0);
      n += int'(STALL);
    end
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 32'h0);
    n += int'(STALL);
    chk("sh_wen", D_MEM_WEN, 0);
    chk("sh_be", D_MEM_BE, 5'b01100);
    chk("sh_addr", D_MEM_ADDR, 32'h200);
    chk("sh_dout", D_MEM_DOUT, 32'hABCDABCD);
    chk("sh_lv", LOAD_VALID, 0);
    chk("sh_stall_cycles", n, 4);
    cyc(1, 0, 2'b10, 0, 32'h101, 32'h0, 1, 32'h0);
    chk("mis_pulse", MISALIGNED, 1);
    chk("mis_stall", STALL, 0);
    chk("mis_csn", D_MEM_CSN, 1);
    idle(1);
    chk("mis_after_csn", D_MEM_CSN, 1);
    chk("mis_after_pulse", MISALIGNED, 0);
    cyc(1, 0, 2'b10, 0, 32'h300, 32'h0, 0, 32'h0);
    for (int i = 0; i < TO; i++) begin
      idle(0);
      chk($sformatf("to_err_%0d", i), TIMEOUT_ERR, i == TO - 1);
      chk($sformatf("to_stall_%0d", i), STALL, i != TO - 1);
      chk($sformatf("to_lv_%0d", i), LOAD_VALID, 0);
    end
    idle(0);
    chk("to_after_csn", D_MEM_CSN, 1);
    chk("to_after_err", TIMEOUT_ERR, 0);
    cyc(1, 0, 2'b10, 0, 32'h400, 32'h0, 0, 32'h0);
    idle(0);
    chk("ar_pre_csn", D_MEM_CSN, 0);
    @(negedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("ar_csn", D_MEM_CSN, 1);
    chk("ar_stall", STALL, 0);
    idle(1);
    RSTn = 1'b1;
    cyc(1, 0, 2'b10, 0, 32'h500, 32'h0, 0, 32'h0);
    cyc(0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 32'h11223344);
    chk("ar_post_lv", LOAD_VALID, 1);
    chk("ar_post_data", LOAD_DATA, 32'h11223344);
    for (int i = 0; i < 800; i++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      cyc($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 7) == 0 ? 2'b11 : 2'($urandom_range(0, 2)),
          1'($urandom), a, $urandom, $urandom_range(0, 2) != 0, $urandom);
    end
    idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
